add_arbiter: RTL and testbench
==============================

# add_arbiter

Round-robin arbiter and result register that shares one `add` datapath among NREQ independent requesters. Each requester presents an add/subtract operation over a valid/ready handshake. The block grants one requester per cycle, drives the shared `add` instance, and registers the sum and flags into a single-entry output stage tagged with the winning requester's index. It sits between the instruction-issue logic of several clients and the single adder those clients share.

## Interface
- `DW`, 4, data width of operands and sum
- `NREQ`, 4, number of requesters (2..16)
- `IW`, $clog2(NREQ), width of the requester index; derived, not overridden
- `clk` in 1: sole clock; all state updates on rising edge
- `rst_n` in 1: reset, synchronous and active-low
- `req_valid` in NREQ: bit i high = requester i presents an operation
- `req_ready` out NREQ: bit i high = requester i's operation is accepted this cycle
- `req_a` in NREQ*DW: operand a; requester i occupies bits [i*DW +: DW]
- `req_b` in NREQ*DW: operand b, same packing
- `req_sub` in NREQ: 1 = subtract, 0 = add
- `req_cin` in NREQ: carry-in (add) or borrow-in (subtract)
- `res_valid` out 1: output register holds a result
- `res_ready` in 1: consumer accepts the result
- `res_id` out IW: index of the requester that produced the result
- `res_sum` out DW: result
- `res_cout` out 1: carry-out (add) or no-borrow (subtract)
- `res_zero`, `res_neg`, `res_overflow` out 1 each: result flags

## Operation
- Shared datapath is one `add` instance, fed combinationally from the granted requester's fields:
  - Add: {cout,sum} = a + b + cin.
  - Subtract: {cout,sum} = a + ~b + ~cin, i.e. a − b − cin; cout = 1 means no borrow.
  - zero = (sum == 0); neg = sum[DW-1].
  - overflow = two's-complement signed overflow of the effective operation.
- `slot_free` = !res_valid | res_ready.
- Grant: when `slot_free`, select the first requester with `req_valid` high, searching from `last+1` upward modulo NREQ. `last` is the index of the most recent accepted requester.
- `req_ready[g]` = slot_free & grant(g). At most one `req_ready` bit is high. Ready depends combinationally on `req_valid` and `res_ready`.
- Accept happens when `req_valid[g]` & `req_ready[g]`. On the next rising edge:
  - the output register loads sum/cout/flags and `res_id` = g;
  - `res_valid` is set to 1;
  - `last` is set to g.
- If `slot_free` is high and no request is accepted, `res_valid` is cleared on the edge if the current result was consumed. Data registers hold their values.
- `res_valid` high with `res_ready` low: all `req_ready` bits are low, and `res_*` and `res_valid` stay stable until consumed.
- Requesters must hold valid and payload stable until accepted. Grant may move to another requester between cycles while a requester waits.
- Fairness: a continuously valid requester is accepted within NREQ accepts.

## Timing
- Reset (rst_n low at a rising edge):
  - `res_valid`=0, `res_id`=0, `res_sum`=0, and all flag outputs = 0;
  - `last`=NREQ-1, so requester 0 has top priority first.
  - `req_ready` = 0 while in reset.
- Reset asserted mid-operation discards any held result with no handshake. The first grant after reset release follows reset priority.
- Latency: accept at edge t → `res_valid` and data visible after edge t.
- Throughput: one result per cycle with `res_ready` held high, including the same requester back-to-back when it is the only one valid.
- Simultaneous consume and accept in one cycle: the register is overwritten with the new result and `res_valid` stays 1 with no bubble.
- Wrap-around: search order after `last`=NREQ-1 starts at 0.

## Test plan
- Reset, then requester 0 issues a=0011, b=0001, add, cin=0, with res_ready=1 → one cycle later: res_valid=1, res_id=0, sum=0100, cout=0, zero=0, neg=0, overflow=0.
- Requester 2 issues a=0010, b=0101, sub, cin=0 → sum=1101, cout=0, neg=1, overflow=0, res_id=2. Then a=0111, b=0001, add → sum=1000, neg=1, overflow=1.
- All four requesters held valid, res_ready=1 → accepts in order 0,1,2,3,0,1 on consecutive cycles; exactly one `req_ready` bit high per cycle.
- res_ready held low for 5 cycles after a result → res_* stable, all req_ready=0. Release res_ready → next grant in the same cycle and a new result the following cycle with no bubble.
- Sub with borrow-in: a=0100, b=0011, cin=1 → sum=0000, zero=1, cout=1. Add a=1111, b=0000, cin=1 → sum=0000, cout=1, zero=1, overflow=0.
- rst_n pulled low while res_valid=1 and requesters are pending → res_valid=0 and all outputs 0 after the edge. After release, requester 0 wins over a pending requester 3.

Source files
------------

// File: rtl/add_arbiter_if.sv
// -----------------------------------------------------------------------------
// add_arbiter_if
// Bundles the requester side and the result side of add_arbiter.
//
// Handshake rule (applies to both req_* and res_*): a transfer happens on a
// rising edge where valid and ready are both high. The source keeps valid and
// payload stable until that transfer; ready may change combinationally.
//
// Signals
//   req_valid[i]         requester i presents an operation
//   req_ready[i]         requester i's operation is accepted this cycle
//   req_a / req_b        operands, requester i in bits [i*DW +: DW]
//   req_sub[i]           1 = subtract, 0 = add
//   req_cin[i]           carry-in (add) / borrow-in (subtract)
//   res_valid/res_ready  result handshake
//   res_id               index of the requester that produced the result
//   res_sum, res_cout    result and carry-out (no-borrow on subtract)
//   res_zero, res_neg, res_overflow   result flags
// Modports: master = requesters + consumer, slave = the arbiter.
// -----------------------------------------------------------------------------
interface add_arbiter_if #(
   parameter int DW   = 4,
   parameter int NREQ = 4
);
   localparam int IW = $clog2(NREQ);

   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*DW-1:0] req_a;
   logic [NREQ*DW-1:0] req_b;
   logic [NREQ-1:0]    req_sub;
   logic [NREQ-1:0]    req_cin;
   logic               res_valid;
   logic               res_ready;
   logic [IW-1:0]      res_id;
   logic [DW-1:0]      res_sum;
   logic               res_cout;
   logic               res_zero;
   logic               res_neg;
   logic               res_overflow;

   modport master (
      output req_valid, req_a, req_b, req_sub, req_cin, res_ready,
      input  req_ready, res_valid, res_id, res_sum, res_cout,
             res_zero, res_neg, res_overflow
   );

   modport slave (
      input  req_valid, req_a, req_b, req_sub, req_cin, res_ready,
      output req_ready, res_valid, res_id, res_sum, res_cout,
             res_zero, res_neg, res_overflow
   );
endinterface

// File: rtl/add_arbiter.sv
// -----------------------------------------------------------------------------
// add / add_arbiter
// add: combinational DW-bit add/subtract with carry and status flags.
//   a, b, sub, cin in; sum, cout, zero, neg, overflow out.
//   Subtract is a + ~b + ~cin, so cout = 1 means no borrow.
// add_arbiter: round-robin arbiter sharing one add instance among NREQ
//   requesters, with a single-entry registered result stage tagged with the
//   winning requester's index.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : add_arbiter_if slave modport (requests in, result out)
// -----------------------------------------------------------------------------
module add #(
   parameter int DW = 4
) (
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic          sub,
   input  logic          cin,
   output logic [DW-1:0] sum,
   output logic          cout,
   output logic          zero,
   output logic          neg,
   output logic          overflow
);
   logic [DW-1:0] b_eff;
   logic          c_eff;

   // Subtract reuses the adder: invert b and the borrow-in.
   assign b_eff = b ^ {DW{sub}};
   assign c_eff = cin ^ sub;

   assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{DW{1'b0}}, c_eff};
   assign zero        = (sum == '0);
   assign neg         = sum[DW-1];
   // Signed overflow: effective operands share a sign the result does not.
   assign overflow    = (a[DW-1] == b_eff[DW-1]) && (sum[DW-1] != a[DW-1]);
endmodule

module add_arbiter #(
   parameter int DW   = 4,
   parameter int NREQ = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   add_arbiter_if.slave bus
);
   localparam int IW = $clog2(NREQ);

   logic [IW-1:0] last;
   logic [IW-1:0] grant_idx;
   logic          grant_found;
   logic [IW-1:0] idx;
   logic          slot_free;
   logic          accept;

   logic [DW-1:0] a_sel;
   logic [DW-1:0] b_sel;
   logic          sub_sel;
   logic          cin_sel;
   logic [DW-1:0] sum_w;
   logic          cout_w;
   logic          zero_w;
   logic          neg_w;
   logic          ovf_w;

   assign slot_free = !bus.res_valid || bus.res_ready;

   // Round-robin search starting one past the most recent winner.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      idx         = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = IW'((int'(last) + k) % NREQ);
         if (!grant_found && bus.req_valid[idx]) begin
            grant_found = 1'b1;
            grant_idx   = idx;
         end
      end
   end

   // Gated by rst_n so no requester sees ready while reset is held.
   assign accept = grant_found && slot_free && rst_n;

   always_comb begin
      bus.req_ready = '0;
      if (accept) begin
         bus.req_ready[grant_idx] = 1'b1;
      end
   end

   assign a_sel   = bus.req_a[int'(grant_idx)*DW +: DW];
   assign b_sel   = bus.req_b[int'(grant_idx)*DW +: DW];
   assign sub_sel = bus.req_sub[grant_idx];
   assign cin_sel = bus.req_cin[grant_idx];

   add #(.DW(DW)) u_add (
      .a        (a_sel),
      .b        (b_sel),
      .sub      (sub_sel),
      .cin      (cin_sel),
      .sum      (sum_w),
      .cout     (cout_w),
      .zero     (zero_w),
      .neg      (neg_w),
      .overflow (ovf_w)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.res_valid    <= 1'b0;
         bus.res_id       <= '0;
         bus.res_sum      <= '0;
         bus.res_cout     <= 1'b0;
         bus.res_zero     <= 1'b0;
         bus.res_neg      <= 1'b0;
         bus.res_overflow <= 1'b0;
         last             <= IW'(NREQ - 1);
      end else if (accept) begin
         // Also covers consume-and-accept in one cycle: overwrite, no bubble.
         bus.res_valid    <= 1'b1;
         bus.res_id       <= grant_idx;
         bus.res_sum      <= sum_w;
         bus.res_cout     <= cout_w;
         bus.res_zero     <= zero_w;
         bus.res_neg      <= neg_w;
         bus.res_overflow <= ovf_w;
         last             <= grant_idx;
      end else if (slot_free) begin
         // Result consumed (or slot already empty); data registers hold.
         bus.res_valid    <= 1'b0;
      end
   end
endmodule

// File: tb/tb_add_arbiter.sv
// -----------------------------------------------------------------------------
// tb_add_arbiter: self-checking bench for add_arbiter (DW=4, NREQ=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge. A reference model predicts grants and results; predicted
// results wait in exp_q until the DUT presents them.
// -----------------------------------------------------------------------------
module tb_add_arbiter;
   localparam int DW   = 4;
   localparam int NREQ = 4;
   localparam int IW   = $clog2(NREQ);
   localparam int RW   = IW + DW + 4;

   logic clk;
   logic rst_n;

   add_arbiter_if #(.DW(DW), .NREQ(NREQ)) bus ();

   add_arbiter #(.DW(DW), .NREQ(NREQ)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   // requester state held by the bench
   logic [NREQ-1:0] v;
   logic [DW-1:0]   ta   [NREQ];
   logic [DW-1:0]   tb   [NREQ];
   logic            tsub [NREQ];
   logic            tcin [NREQ];

   // model state
   logic [RW-1:0] exp_q[$];
   logic          m_valid;
   int            m_last;

   // {id, sum, cout, zero, neg, ovf} computed with plain integer arithmetic
   function automatic logic [RW-1:0] exp_calc(input int id, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b, input logic sub,
                                              input logic cin);
      int full, sa, sb, sres, s;
      logic c, z, n, o;
      full = sub ? (int'(a) - int'(b) - int'(cin)) : (int'(a) + int'(b) + int'(cin));
      s    = full & ((1 << DW) - 1);
      c    = sub ? (full >= 0) : (full >= (1 << DW));
      sa   = (a[DW-1]) ? int'(a) - (1 << DW) : int'(a);
      sb   = (b[DW-1]) ? int'(b) - (1 << DW) : int'(b);
      sres = sub ? (sa - sb - int'(cin)) : (sa + sb + int'(cin));
      o    = (sres > (1 << (DW-1)) - 1) || (sres < -(1 << (DW-1)));
      z    = (s == 0);
      n    = ((s >> (DW-1)) & 1) == 1;
      return {IW'(id), DW'(s), c, z, n, o};
   endfunction

   // driver tasks
   task automatic drive();
      bus.req_valid = v;
      for (int i = 0; i < NREQ; i++) begin
         bus.req_a[i*DW +: DW] = ta[i];
         bus.req_b[i*DW +: DW] = tb[i];
         bus.req_sub[i]        = tsub[i];
         bus.req_cin[i]        = tcin[i];
      end
   endtask

   task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic sub, input logic cin);
      ta[i] = a; tb[i] = b; tsub[i] = sub; tcin[i] = cin; v[i] = 1'b1;
      drive();
   endtask

   // One clock cycle: check outputs against the model, predict the grant,
   // update the scoreboard, advance past the rising edge.
   task automatic step(input bit clr, output logic acc, output int gid);
      logic            free;
      logic [NREQ-1:0] exp_rdy;
      logic [RW-1:0]   got;
      int              idx;
      @(negedge clk);
      acc = 1'b0;
      gid = -1;
      tests_run++;
      if (bus.res_valid !== m_valid) begin
         tests_failed++;
         $display("FAIL res_valid: got %b expected %b at %0t", bus.res_valid, m_valid, $time);
      end
      if (m_valid && exp_q.size() > 0) begin
         got = {bus.res_id, bus.res_sum, bus.res_cout, bus.res_zero, bus.res_neg, bus.res_overflow};
         tests_run++;
         if (got !== exp_q[0]) begin
            tests_failed++;
            $display("FAIL result {id,sum,c,z,n,o}: got %b expected %b at %0t", got, exp_q[0], $time);
         end
      end
      free    = !m_valid || bus.res_ready;
      exp_rdy = '0;
      if (free) begin
         for (int k = 1; k <= NREQ; k++) begin
            idx = (m_last + k) % NREQ;
            if (gid < 0 && v[idx]) gid = idx;
         end
      end
      if (gid >= 0) exp_rdy[gid] = 1'b1;
      tests_run++;
      if (bus.req_ready !== exp_rdy) begin
         tests_failed++;
         $display("FAIL req_ready: got %b expected %b at %0t", bus.req_ready, exp_rdy, $time);
      end
      if (m_valid && bus.res_ready) void'(exp_q.pop_front());
      if (gid >= 0) begin
         acc = 1'b1;
         exp_q.push_back(exp_calc(gid, ta[gid], tb[gid], tsub[gid], tcin[gid]));
         m_valid = 1'b1;
         m_last  = gid;
      end else if (free) begin
         m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      if (clr && acc) begin
         v[gid] = 1'b0;
         drive();
      end
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      drive();
      @(posedge clk);
      #1;
      @(negedge clk);
      tests_run++;
      if ({bus.res_valid, bus.res_id, bus.res_sum, bus.res_cout, bus.res_zero,
           bus.res_neg, bus.res_overflow} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got valid=%b id=%0d sum=%b c=%b z=%b n=%b o=%b expected all 0",
                  bus.res_valid, bus.res_id, bus.res_sum, bus.res_cout, bus.res_zero,
                  bus.res_neg, bus.res_overflow);
      end
      tests_run++;
      if (bus.req_ready !== '0) begin
         tests_failed++;
         $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready);
      end
      exp_q.delete();
      m_valid = 1'b0;
      m_last  = NREQ - 1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Present one operation on requester i and wait (bounded) for its accept.
   task automatic issue(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic sub, input logic cin);
      logic acc;
      int   gid;
      bit   done;
      done = 0;
      set_req(i, a, b, sub, cin);
      for (int n = 0; n < 20 && !done; n++) begin
         step(1'b1, acc, gid);
         if (acc && gid == i) done = 1;
      end
      if (!done) begin
         tests_run++;
         tests_failed++;
         $display("FAIL issue_timeout: requester %0d not accepted within 20 cycles", i);
         v[i] = 1'b0;
         drive();
      end
   endtask

   task automatic idle(input int n);
      logic acc;
      int   gid;
      for (int k = 0; k < n; k++) step(1'b1, acc, gid);
   endtask

   // scenarios
   task automatic test_reset();
      v = '1;
      for (int i = 0; i < NREQ; i++) begin
         ta[i] = DW'(i); tb[i] = '0; tsub[i] = 1'b0; tcin[i] = 1'b0;
      end
      apply_reset();
      v = '0;
      drive();
   endtask

   task automatic test_add_basic();
      bus.res_ready = 1'b1;
      issue(0, 4'b0011, 4'b0001, 1'b0, 1'b0);
      idle(2);
   endtask

   task automatic test_sub_overflow();
      bus.res_ready = 1'b1;
      issue(2, 4'b0010, 4'b0101, 1'b1, 1'b0);
      issue(2, 4'b0111, 4'b0001, 1'b0, 1'b0);
      idle(2);
   endtask

   task automatic test_round_robin();
      logic acc;
      int   gid;
      v = '0;
      apply_reset();
      bus.res_ready = 1'b1;
      for (int i = 0; i < NREQ; i++) set_req(i, DW'(i + 1), DW'(2 * i), 1'b0, 1'(i & 1));
      for (int k = 0; k < 6; k++) begin
         step(1'b0, acc, gid);
         tests_run++;
         if (gid !== k % NREQ) begin
            tests_failed++;
            $display("FAIL rr_order cycle %0d: got %0d expected %0d", k, gid, k % NREQ);
         end
      end
      v = '0;
      drive();
      idle(2);
   endtask

   task automatic test_back_to_back();
      logic acc;
      int   gid;
      bus.res_ready = 1'b1;
      issue(1, 4'b0101, 4'b0110, 1'b0, 1'b0);
      bus.res_ready = 1'b0;
      set_req(0, 4'b1001, 4'b0011, 1'b1, 1'b0);
      set_req(3, 4'b0110, 4'b0110, 1'b0, 1'b1);
      for (int k = 0; k < 5; k++) step(1'b1, acc, gid);
      bus.res_ready = 1'b1;
      step(1'b1, acc, gid);
      tests_run++;
      if (gid !== 3) begin
         tests_failed++;
         $display("FAIL release_grant: got %0d expected 3", gid);
      end
      idle(4);
   endtask

   task automatic test_borrow();
      bus.res_ready = 1'b1;
      issue(1, 4'b0100, 4'b0011, 1'b1, 1'b1);
      issue(3, 4'b1111, 4'b0000, 1'b0, 1'b1);
      idle(2);
   endtask

   task automatic test_reset_mid();
      logic acc;
      int   gid;
      bus.res_ready = 1'b1;
      issue(2, 4'b0001, 4'b0001, 1'b0, 1'b0);
      bus.res_ready = 1'b0;
      set_req(1, 4'b0011, 4'b0001, 1'b0, 1'b0);
      set_req(3, 4'b0111, 4'b0010, 1'b1, 1'b0);
      step(1'b1, acc, gid);
      apply_reset();
      bus.res_ready = 1'b1;
      v[1] = 1'b0;
      set_req(0, 4'b1000, 4'b1000, 1'b0, 1'b0);
      step(1'b1, acc, gid);
      tests_run++;
      if (gid !== 0) begin
         tests_failed++;
         $display("FAIL post_reset_grant: got %0d expected 0", gid);
      end
      idle(4);
   endtask

   task automatic test_random();
      logic acc;
      int   gid;
      bit   drained;
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!v[i] && $urandom_range(0, 2) == 0) begin
               ta[i] = DW'($urandom_range(0, 15)); tb[i] = DW'($urandom_range(0, 15));
               tsub[i] = 1'($urandom_range(0, 1)); tcin[i] = 1'($urandom_range(0, 1));
               v[i] = 1'b1;
            end
         end
         bus.res_ready = ($urandom_range(0, 3) != 0);
         drive();
         step(1'b1, acc, gid);
      end
      bus.res_ready = 1'b1;
      drained = 0;
      for (int n = 0; n < 50 && !drained; n++) begin
         step(1'b1, acc, gid);
         if (v == '0 && !m_valid) drained = 1;
      end
      tests_run++;
      if (!drained) begin
         tests_failed++;
         $display("FAIL drain: pending=%b held=%b expected all drained", v, m_valid);
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      v             = '0;
      bus.res_ready = 1'b0;
      m_valid       = 1'b0;
      m_last        = NREQ - 1;
      for (int i = 0; i < NREQ; i++) begin
         ta[i] = '0; tb[i] = '0; tsub[i] = 1'b0; tcin[i] = 1'b0;
      end
      drive();
      @(posedge clk);
      #1;
      test_reset();
      test_add_basic();
      test_sub_overflow();
      test_round_robin();
      test_back_to_back();
      test_borrow();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
